img_template_match: RTL
=======================

// Module: img_template_match
// PURPOSE
//  Parametrised, writable successor to the fixed 16x16 template lookup in the camera path.
//  Holds a runtime-loadable template of 2^TPL_LOG2 x 2^TPL_LOG2 cells, each cell covering 2^HALVING x 2^HALVING pixels.
//  Maps each streamed pixel coordinate to a cell and compares the pixel with the template value.
//  Accumulates a saturating sum of absolute differences (SAD) per frame; sits after the Bayer/RGB-to-gray stage, before the overlay/VGA logic.
// PARAMETERS
//  DATA_W   10  pixel and template value width
//  COORD_W  13  width of pixel X/Y coordinates
//  TPL_LOG2 4   log2 of template side in cells (4 -> 16x16 = 256 cells)
//  HALVING  4   log2 of cell side in pixels
//  SAD_W    28  SAD accumulator width; saturates at all-ones
// PORTS
//  iCLK      in  1        clock
//  iRST      in  1        asynchronous reset, active-high
//  iWR_EN    in  1        template write strobe
//  iWR_ADDR  in  2*TPL_LOG2  cell address = row*2^TPL_LOG2 + col
//  iWR_DATA  in  DATA_W   template cell value
//  iORG_X    in  COORD_W  window origin X, sampled when iSTART is accepted
//  iORG_Y    in  COORD_W  window origin Y, sampled when iSTART is accepted
//  iSTART    in  1        begin a frame: clear accumulators, enter RUN
//  iFRAME_END in 1        last pixel of frame has been presented
//  iDVAL     in  1        pixel valid
//  iX        in  COORD_W  pixel X
//  iY        in  COORD_W  pixel Y
//  iDATA     in  DATA_W   pixel value
//  oTPL_VAL  out 1        oTPL carries a valid in-window lookup
//  oTPL      out DATA_W   template value for the pixel issued 3 cycles earlier
//  oBUSY     out 1        high in RUN and FLUSH
//  oDONE     out 1        one-cycle pulse; oSCORE/oHITS valid
//  oSCORE    out SAD_W    frame SAD, held until the next iSTART
//  oHITS     out 2*COORD_W  in-window pixel count for the frame, held like oSCORE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pipeline valids 0; origin regs 0. Template RAM is not reset.
//  FSM: IDLE -iSTART-> RUN -iFRAME_END-> FLUSH -(3 cycles)-> DONE -> IDLE.
//   - DONE lasts one cycle and drives oDONE=1.
//   - iSTART in any state: clear SAD/hits and pipeline valids, latch the origin, go to RUN.
//   - iSTART has priority over iFRAME_END when both are high in the same cycle.
//   - iFRAME_END outside RUN is ignored.
//  Writes: accepted only in IDLE/DONE; ignored while oBUSY=1. RAM read is synchronous.
//   - A write and a lookup of the same cell in the same cycle cannot occur, since lookups exist only in RUN.
//  Pipeline (pixels accepted only in RUN with iDVAL=1; FLUSH still drains stages):
//   S0: dx=iX-ORG_X, dy=iY-ORG_Y, computed COORD_W+1 wide and signed.
//       in-window iff dx>=0, dy>=0, dx>>HALVING < 2^TPL_LOG2, and dy>>HALVING < 2^TPL_LOG2.
//       addr = (dy>>HALVING)<<TPL_LOG2 | (dx>>HALVING).
//   S1: RAM read; pixel and in-window flag delayed to match.
//   S2: |pixel - tpl| computed unsigned, DATA_W bits.
//       oTPL_VAL = valid & in_window; oTPL = template value when valid, otherwise held.
//       Latency iDVAL -> oTPL_VAL is 3 cycles.
//   S2 accumulate: when oTPL_VAL=1, SAD += diff saturating at 2^SAD_W-1, and hits += 1 saturating.
//   Out-of-window pixels contribute nothing.
//  FLUSH: 3 cycles, so the last pixel, presented with or before iFRAME_END, is accumulated before DONE.
//  oSCORE/oHITS are updated in the DONE cycle and held until iSTART clears them.
//  iRST mid-frame: immediate return to IDLE with all outputs 0; template contents are preserved.
// TESTING
//  1. Load all cells with 429; origin (0,0); 256x256 frame of pixels =429.
//     -> oDONE once 3 cycles after FLUSH entry; oSCORE=0, oHITS=65536.
//  2. Same template; pixel 1023 at (17,0) only (single iDVAL).
//     -> oTPL=429 with oTPL_VAL exactly 3 cycles later; oSCORE=594, oHITS=1.
//  3. Origin (100,50); pixels at (99,50), (100,49), (356,50) -> oTPL_VAL never set, oHITS=0.
//     Pixel at (100,50) -> cell 0 lookup, oHITS=1.
//  4. SAD_W=12 override; template 0; 16 in-window pixels of 1023.
//     -> oSCORE saturates at 4095 and does not wrap.
//  5. Write cell 5 = 77 while oBUSY=1 -> RAM unchanged (lookup still returns the old value).
//     The same write in IDLE -> a lookup at cell 5 returns 77.
//  6. iSTART and iFRAME_END together mid-RUN -> accumulators clear, stay in RUN, no oDONE.
//     iRST mid-FLUSH -> oDONE never pulses; template retained.

Source files
------------

// File: rtl/img_template_match_if.sv
// Bus bundle for img_template_match: template write port, frame control, pixel stream and results.
`timescale 1ns/1ps
interface img_template_match_if #(
    parameter int DATA_W   = 10,
    parameter int COORD_W  = 13,
    parameter int TPL_LOG2 = 4,
    parameter int SAD_W    = 28
);
    logic                    iWR_EN;
    logic [2*TPL_LOG2-1:0]   iWR_ADDR;
    logic [DATA_W-1:0]       iWR_DATA;
    logic [COORD_W-1:0]      iORG_X;
    logic [COORD_W-1:0]      iORG_Y;
    logic                    iSTART;
    logic                    iFRAME_END;
    logic                    iDVAL;
    logic [COORD_W-1:0]      iX;
    logic [COORD_W-1:0]      iY;
    logic [DATA_W-1:0]       iDATA;
    logic                    oTPL_VAL;
    logic [DATA_W-1:0]       oTPL;
    logic                    oBUSY;
    logic                    oDONE;
    logic [SAD_W-1:0]        oSCORE;
    logic [2*COORD_W-1:0]    oHITS;

    modport master (
        output iWR_EN, iWR_ADDR, iWR_DATA, iORG_X, iORG_Y, iSTART, iFRAME_END,
               iDVAL, iX, iY, iDATA,
        input  oTPL_VAL, oTPL, oBUSY, oDONE, oSCORE, oHITS
    );

    modport slave (
        input  iWR_EN, iWR_ADDR, iWR_DATA, iORG_X, iORG_Y, iSTART, iFRAME_END,
               iDVAL, iX, iY, iDATA,
        output oTPL_VAL, oTPL, oBUSY, oDONE, oSCORE, oHITS
    );
endinterface

// File: rtl/img_template_match.sv
// Writable template lookup over a pixel window with a per-frame saturating SAD and hit count.
// state | meaning
// IDLE  | waiting for iSTART; template writes allowed
// RUN   | accepting pixels into the 3-stage lookup pipeline
// FLUSH | 3 cycles draining the pipeline after iFRAME_END
// DONE  | one cycle: oDONE high, oSCORE/oHITS just updated; writes allowed
`timescale 1ns/1ps
module img_template_match #(
    parameter int DATA_W   = 10,
    parameter int COORD_W  = 13,
    parameter int TPL_LOG2 = 4,
    parameter int HALVING  = 4,
    parameter int SAD_W    = 28
) (
    input  logic               iCLK,
    input  logic               iRST,
    img_template_match_if.slave bus
);
    localparam int AW    = 2 * TPL_LOG2;
    localparam int HW    = 2 * COORD_W;
    localparam int WIN   = 2 ** (TPL_LOG2 + HALVING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         flush_q, flush_d;
    logic [SAD_W-1:0]   sad_q, sad_d, score_q, score_d;
    logic [HW-1:0]      hits_q, hits_d, hits_out_q, hits_out_d;

    logic [COORD_W-1:0] org_x_q, org_y_q;
    logic               s0_vld_q, s0_inwin_q, s1_vld_q, s1_inwin_q, tpl_val_q;
    logic [AW-1:0]      s0_addr_q;
    logic [DATA_W-1:0]  s0_pix_q, s1_pix_q, rd_q, tpl_q, diff_q;

    logic [DATA_W-1:0]  mem [2**AW];

    logic signed [COORD_W:0] dx, dy;
    logic               inwin;
    logic [AW-1:0]      addr;
    logic [DATA_W-1:0]  diff;
    logic [SAD_W:0]     sad_sum;
    logic               wr_ok;

    assign dx    = $signed({1'b0, bus.iX}) - $signed({1'b0, org_x_q});
    assign dy    = $signed({1'b0, bus.iY}) - $signed({1'b0, org_y_q});
    assign inwin = !dx[COORD_W] && !dy[COORD_W]
                && (dx[COORD_W-1:0] < COORD_W'(WIN)) && (dy[COORD_W-1:0] < COORD_W'(WIN));
    assign addr  = {dy[HALVING+TPL_LOG2-1:HALVING], dx[HALVING+TPL_LOG2-1:HALVING]};
    assign diff  = (s1_pix_q >= rd_q) ? (s1_pix_q - rd_q) : (rd_q - s1_pix_q);
    assign sad_sum = {1'b0, sad_q} + (SAD_W+1)'(diff_q);
    assign wr_ok = (state_q == S_IDLE) || (state_q == S_DONE);

    // Template RAM has no reset so its contents survive iRST.
    always_ff @(posedge iCLK) begin
        if (wr_ok && bus.iWR_EN)
            mem[bus.iWR_ADDR] <= bus.iWR_DATA;
        rd_q <= mem[s0_addr_q];
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            org_x_q    <= '0;
            org_y_q    <= '0;
            s0_vld_q   <= 1'b0;
            s0_inwin_q <= 1'b0;
            s0_addr_q  <= '0;
            s0_pix_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_inwin_q <= 1'b0;
            s1_pix_q   <= '0;
            tpl_val_q  <= 1'b0;
            tpl_q      <= '0;
            diff_q     <= '0;
        end else if (bus.iSTART) begin
            org_x_q   <= bus.iORG_X;
            org_y_q   <= bus.iORG_Y;
            s0_vld_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            tpl_val_q <= 1'b0;
        end else begin
            s0_vld_q   <= (state_q == S_RUN) && bus.iDVAL;
            s0_inwin_q <= inwin;
            s0_addr_q  <= addr;
            s0_pix_q   <= bus.iDATA;
            s1_vld_q   <= s0_vld_q;
            s1_inwin_q <= s0_inwin_q;
            s1_pix_q   <= s0_pix_q;
            tpl_val_q  <= s1_vld_q && s1_inwin_q;
            if (s1_vld_q)
                tpl_q <= rd_q;
            diff_q     <= diff;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            flush_q    <= '0;
            sad_q      <= '0;
            hits_q     <= '0;
            score_q    <= '0;
            hits_out_q <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            sad_q      <= sad_d;
            hits_q     <= hits_d;
            score_q    <= score_d;
            hits_out_q <= hits_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        sad_d      = sad_q;
        hits_d     = hits_q;
        score_d    = score_q;
        hits_out_d = hits_out_q;
        if (tpl_val_q) begin
            sad_d  = sad_sum[SAD_W] ? '1 : sad_sum[SAD_W-1:0];
            hits_d = (&hits_q) ? hits_q : hits_q + HW'(1);
        end
        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                if (bus.iFRAME_END) begin
                    state_d = S_FLUSH;
                    flush_d = 2'd2;
                end
            end
            S_FLUSH: begin
                // Last flush cycle: results include the final accumulate.
                if (flush_q == 2'd0) begin
                    state_d    = S_DONE;
                    score_d    = sad_d;
                    hits_out_d = hits_d;
                end else begin
                    flush_d = flush_q - 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.iSTART) begin
            state_d    = S_RUN;
            sad_d      = '0;
            hits_d     = '0;
            score_d    = '0;
            hits_out_d = '0;
        end
    end

    assign bus.oTPL_VAL = tpl_val_q;
    assign bus.oTPL     = tpl_q;
    assign bus.oBUSY    = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign bus.oDONE    = (state_q == S_DONE);
    assign bus.oSCORE   = score_q;
    assign bus.oHITS    = hits_out_q;
endmodule
